// File: rtl/bp_update_engine.sv
// Branch predictor update engine: write side of the BTB + 2-bit direction table.
// Accepts one resolved instruction per cycle, raises a registered flush/redirect on a
// mispredicted branch, and queues table-update packets to the predictor through a small
// valid/ready FIFO. After reset it first sweeps every table entry to the invalid state.

module bp_update_engine #(
  parameter int unsigned IDX_BITS   = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  // Resolve stage
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic                 res_is_branch,
  input  logic [15:0]          res_pc,
  input  logic                 res_pred_taken,
  input  logic [15:0]          res_pred_target,
  input  logic                 res_taken,
  input  logic [15:0]          res_target,
  // Fetch redirect
  output logic                 flush,
  output logic [15:0]          redirect_pc,
  // Predictor update port
  output logic                 upd_valid,
  input  logic                 upd_ready,
  output logic                 upd_clear,
  output logic [IDX_BITS-1:0]  upd_index,
  output logic [15-IDX_BITS:0] upd_tag,
  output logic [15:0]          upd_target,
  output logic                 upd_taken,
  // Status
  output logic                 init_done,
  output logic [15:0]          branch_count,
  output logic [15:0]          mispred_count
);

  localparam int unsigned TagBits = 16 - IDX_BITS;
  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic [TagBits-1:0]  tag;
    logic [15:0]         target;
    logic                taken;
  } pkt_t;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] sweep_idx_q, sweep_idx_d;

  pkt_t                fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       count_q, count_d;

  logic                flush_q, flush_d;
  logic [15:0]         redirect_q, redirect_d;
  logic [15:0]         branch_cnt_q, branch_cnt_d;
  logic [15:0]         mispred_cnt_q, mispred_cnt_d;

  logic                fifo_empty;
  logic                fifo_full;
  logic                accept_br;
  logic                mis;
  logic                upd_fire;
  logic                push;
  logic                pop;
  pkt_t                head;
  pkt_t                new_pkt;

  // Handshake decode and misprediction detection
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    // Full blocks acceptance even if a pop happens this cycle, keeping ready off the pop path
    res_ready  = (state_q == StRun) && !fifo_full;
    accept_br  = res_valid && res_ready && res_is_branch;
    mis        = (res_pred_taken != res_taken) ||
                 (res_taken && (res_pred_target != res_target));
    upd_fire   = upd_valid && upd_ready;
    push       = accept_br;
    pop        = (state_q == StRun) && upd_fire;
    new_pkt    = '{idx:    res_pc[IDX_BITS-1:0],
                   tag:    res_pc[15:IDX_BITS],
                   target: res_target,
                   taken:  res_taken};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StInit;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  // FSM next state: sweep advances only on a completed handshake
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    unique case (state_q)
      StInit: begin
        if (upd_fire) begin
          sweep_idx_d = sweep_idx_q + 1'b1;
          if (sweep_idx_q == '1) begin
            state_d = StRun;
          end
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // FSM outputs: sweep packets bypass the FIFO during INIT
  always_comb begin
    head = fifo_mem_q[rd_ptr_q];
    unique case (state_q)
      StInit: begin
        upd_valid  = 1'b1;
        upd_clear  = 1'b1;
        upd_index  = sweep_idx_q;
        upd_tag    = '0;
        upd_target = 16'hFFFF;
        upd_taken  = 1'b0;
        init_done  = 1'b0;
      end
      default: begin
        upd_valid  = !fifo_empty;
        upd_clear  = 1'b0;
        upd_index  = head.idx;
        upd_tag    = head.tag;
        upd_target = head.target;
        upd_taken  = head.taken;
        init_done  = 1'b1;
      end
    endcase
  end

  // FIFO pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO payload storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= new_pkt;
    end
  end

  // Flush/redirect and saturating statistics next state
  always_comb begin
    flush_d       = accept_br && mis;
    redirect_d    = redirect_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (accept_br && mis) begin
      redirect_d = res_taken ? res_target : (res_pc + 16'd1);
    end
    if (accept_br && (branch_cnt_q != 16'hFFFF)) begin
      branch_cnt_d = branch_cnt_q + 16'd1;
    end
    if (accept_br && mis && (mispred_cnt_q != 16'hFFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 16'd1;
    end
  end

  // Flush/redirect and statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign flush         = flush_q;
  assign redirect_pc   = redirect_q;
  assign branch_count  = branch_cnt_q;
  assign mispred_count = mispred_cnt_q;

endmodule

// File: tb/tb_bp_update_engine.sv
// Directed bench for bp_update_engine: init sweep, mispredict flush, FIFO backpressure
// and reset mid-run. Expected update packets are queued when a branch is accepted and
// compared in order as the predictor port hands them over.

module tb_bp_update_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid;
  logic        res_ready;
  logic        res_is_branch;
  logic [15:0] res_pc;
  logic        res_pred_taken;
  logic [15:0] res_pred_target;
  logic        res_taken;
  logic [15:0] res_target;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        upd_valid;
  logic        upd_ready;
  logic        upd_clear;
  logic [7:0]  upd_index;
  logic [7:0]  upd_tag;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic        init_done;
  logic [15:0] branch_count;
  logic [15:0] mispred_count;

  typedef struct packed {
    logic [7:0]  idx;
    logic [7:0]  tag;
    logic [15:0] target;
    logic        taken;
  } pkt_t;

  pkt_t        exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_sweep = 0;
  logic        stall_pend = 1'b0;
  logic        stall_clr;
  pkt_t        stall_pkt;
  pkt_t        scratch;
  logic [15:0] pc_k;
  logic [15:0] tgt_k;

  always #5 clk = ~clk;

  bp_update_engine #(
    .IDX_BITS  (8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_is_branch  (res_is_branch),
    .res_pc         (res_pc),
    .res_pred_taken (res_pred_taken),
    .res_pred_target(res_pred_target),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_clear      (upd_clear),
    .upd_index      (upd_index),
    .upd_tag        (upd_tag),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .init_done      (init_done),
    .branch_count   (branch_count),
    .mispred_count  (mispred_count)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Predictor-side monitor, run once per cycle at the falling edge
  task automatic mon();
    pkt_t cur;
    pkt_t e;
    cur = {upd_index, upd_tag, upd_target, upd_taken};
    if (reset) begin
      stall_pend = 1'b0;
      return;
    end
    if (stall_pend) begin
      chk("stall_hold", {upd_valid, upd_clear, cur}, {1'b1, stall_clr, stall_pkt});
    end
    if (upd_valid && upd_ready) begin
      if (upd_clear) begin
        chk("sweep_pkt", cur, {exp_sweep[7:0], 8'h00, 16'hFFFF, 1'b0});
        exp_sweep++;
      end else if (exp_q.size() == 0) begin
        chk("spurious_pkt", upd_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("upd_pkt", cur, e);
      end
    end
    stall_pend = upd_valid && !upd_ready;
    stall_clr  = upd_clear;
    stall_pkt  = cur;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    mon();
  endtask

  task automatic cyc();
    tick();
    sample();
  endtask

  task automatic do_reset();
    tick();
    reset     = 1'b1;
    res_valid = 1'b0;
    sample();
    tick();
    reset     = 1'b0;
    exp_sweep = 0;
    exp_q.delete();
  endtask

  // Entered at posedge+1 of the first post-reset cycle; leaves at a falling edge
  task automatic run_sweep(input bit toggle, input int exp_cycles);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    upd_ready = !toggle;
    for (int i = 0; i < 1200 && !done; i++) begin
      sample();
      if (init_done) begin
        done = 1'b1;
      end else begin
        n++;
        tick();
        if (toggle) upd_ready = !upd_ready;
      end
    end
    chk("sweep_done", done, 1'b1);
    chk("sweep_cycles", n, exp_cycles);
    chk("sweep_count", exp_sweep, 256);
    chk("run_res_ready", res_ready, 1'b1);
    chk("run_upd_valid", upd_valid, 1'b0);
  endtask

  // One instruction offered for a single cycle; leaves at the falling edge after accept
  task automatic send(input logic is_br, input logic [15:0] pc, input logic pt,
                      input logic [15:0] ptgt, input logic t, input logic [15:0] tgt);
    pkt_t p;
    tick();
    res_valid       = 1'b1;
    res_is_branch   = is_br;
    res_pc          = pc;
    res_pred_taken  = pt;
    res_pred_target = ptgt;
    res_taken       = t;
    res_target      = tgt;
    sample();
    chk("send_ready", res_ready, 1'b1);
    if (exp_q.size() == 0) chk("pkt_not_early", upd_valid, 1'b0);
    if (is_br) begin
      p = {pc[7:0], pc[15:8], tgt, t};
      exp_q.push_back(p);
    end
    tick();
    res_valid = 1'b0;
    sample();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    res_valid       = 1'b0;
    res_is_branch   = 1'b0;
    res_pc          = '0;
    res_pred_taken  = 1'b0;
    res_pred_target = '0;
    res_taken       = 1'b0;
    res_target      = '0;
    upd_ready       = 1'b1;

    // Reset state
    tick();
    sample();
    chk("rst_flush", flush, 1'b0);
    chk("rst_redirect", redirect_pc, 16'h0000);
    chk("rst_res_ready", res_ready, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_branch_cnt", branch_count, 16'h0000);
    chk("rst_mispred_cnt", mispred_count, 16'h0000);
    chk("rst_sweep_head", {upd_valid, upd_clear, upd_index}, {1'b1, 1'b1, 8'h00});
    tick();
    reset = 1'b0;

    // T1: sweep with predictor always ready
    run_sweep(1'b0, 256);

    // T2: sweep with ready toggling every cycle
    do_reset();
    run_sweep(1'b1, 512);

    // T3: not-taken prediction, actually taken
    tick();
    upd_ready = 1'b1;
    sample();
    send(1'b1, 16'h0120, 1'b0, 16'h0121, 1'b1, 16'h0130);
    chk("t3_flush", flush, 1'b1);
    chk("t3_redirect", redirect_pc, 16'h0130);
    chk("t3_mispred", mispred_count, 16'd1);
    chk("t3_branch", branch_count, 16'd1);
    cyc();
    chk("t3_flush_pulse", flush, 1'b0);
    chk("t3_drained", exp_q.size(), 0);

    // T4: fall-through wrap, correct prediction, wrong target, non-branch, idle valid
    send(1'b1, 16'hFFFF, 1'b1, 16'h1234, 1'b0, 16'h5555);
    chk("t4_wrap_flush", flush, 1'b1);
    chk("t4_wrap_redirect", redirect_pc, 16'h0000);
    send(1'b1, 16'h0200, 1'b1, 16'h0250, 1'b1, 16'h0250);
    chk("t4_hit_flush", flush, 1'b0);
    chk("t4_hit_counts", {branch_count, mispred_count}, {16'd3, 16'd2});
    send(1'b1, 16'h0300, 1'b1, 16'h0310, 1'b1, 16'h0320);
    chk("t4_tgt_flush", flush, 1'b1);
    chk("t4_tgt_redirect", redirect_pc, 16'h0320);
    chk("t4_tgt_counts", {branch_count, mispred_count}, {16'd4, 16'd3});
    send(1'b0, 16'h0400, 1'b0, 16'h0000, 1'b1, 16'h0500);
    chk("t4_nonbr_flush", flush, 1'b0);
    chk("t4_nonbr_counts", {branch_count, mispred_count}, {16'd4, 16'd3});
    chk("t4_nonbr_no_pkt", upd_valid, 1'b0);
    send(1'b1, 16'h0410, 1'b0, 16'h9999, 1'b0, 16'h0440);
    chk("t4_nt_flush", flush, 1'b0);
    tick();
    res_valid      = 1'b0;
    res_is_branch  = 1'b1;
    res_pred_taken = 1'b0;
    res_taken      = 1'b1;
    sample();
    cyc();
    chk("t4_idle_flush", flush, 1'b0);
    chk("t4_idle_counts", {branch_count, mispred_count}, {16'd5, 16'd3});
    chk("t4_drained", exp_q.size(), 0);

    // T5: predictor stalled, five back-to-back branches
    tick();
    upd_ready     = 1'b0;
    res_is_branch = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pc_k            = 16'h1001 + 16'(k);
      tgt_k           = 16'h2000 + 16'(k);
      res_valid       = 1'b1;
      res_pc          = pc_k;
      res_taken       = k[0];
      res_pred_taken  = k[0];
      res_target      = tgt_k;
      res_pred_target = tgt_k;
      sample();
      chk("t5_ready", res_ready, (k < 4));
      if (k < 4) begin
        scratch = {pc_k[7:0], pc_k[15:8], tgt_k, k[0]};
        exp_q.push_back(scratch);
      end
      tick();
    end
    upd_ready = 1'b1;
    sample();
    chk("t5_full_pop_ready", res_ready, 1'b0);
    tick();
    sample();
    chk("t5_refill_ready", res_ready, 1'b1);
    scratch = {pc_k[7:0], pc_k[15:8], tgt_k, 1'b0};
    exp_q.push_back(scratch);
    tick();
    res_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      sample();
      tick();
    end
    sample();
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_empty", upd_valid, 1'b0);
    chk("t5_counts", {branch_count, mispred_count}, {16'd10, 16'd3});

    // T6: reset with three packets queued and a flush pending
    tick();
    upd_ready = 1'b0;
    sample();
    send(1'b1, 16'h0A00, 1'b0, 16'h0000, 1'b0, 16'h0A10);
    send(1'b1, 16'h0B00, 1'b1, 16'h0B20, 1'b1, 16'h0B20);
    tick();
    res_valid       = 1'b1;
    res_is_branch   = 1'b1;
    res_pc          = 16'h0C00;
    res_pred_taken  = 1'b1;
    res_pred_target = 16'h0C40;
    res_taken       = 1'b0;
    res_target      = 16'h0C80;
    sample();
    chk("t6_ready", res_ready, 1'b1);
    tick();
    res_valid = 1'b0;
    reset     = 1'b1;
    sample();
    chk("t6_pre_flush", flush, 1'b1);
    chk("t6_pre_redirect", redirect_pc, 16'h0C01);
    tick();
    reset     = 1'b0;
    exp_sweep = 0;
    exp_q.delete();
    sample();
    chk("t6_flush", flush, 1'b0);
    chk("t6_redirect", redirect_pc, 16'h0000);
    chk("t6_sweep_head", {upd_valid, upd_clear, upd_index}, {1'b1, 1'b1, 8'h00});
    chk("t6_counts", {branch_count, mispred_count}, {16'd0, 16'd0});
    chk("t6_init", {init_done, res_ready}, {1'b0, 1'b0});
    tick();
    run_sweep(1'b0, 256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
